// File: rtl/zigzag_rle_if.sv
// Block-in / symbol-out bundle for zigzag_rle: coefficient capture strobe plus
// the (run, value, eob) valid/ready stream toward the entropy coder.
interface zigzag_rle_if #(
    parameter int unsigned COEFF_W = 52,
    parameter int unsigned VAL_W   = 16
) ();
    logic                                block_done;
    logic [7:0][7:0][COEFF_W-1:0]        quantized_coeffs;
    logic                                in_ready;
    logic                                out_valid;
    logic                                out_ready;
    logic [3:0]                          out_run;
    logic signed [VAL_W-1:0]             out_value;
    logic                                out_eob;
    logic                                block_sent;

    // Environment side: supplies blocks, consumes symbols.
    modport master (
        output block_done, quantized_coeffs, out_ready,
        input  in_ready, out_valid, out_run, out_value, out_eob, block_sent
    );

    // The zigzag/RLE stage itself.
    modport slave (
        input  block_done, quantized_coeffs, out_ready,
        output in_ready, out_valid, out_run, out_value, out_eob, block_sent
    );
endinterface

// File: rtl/zigzag_rle.sv
// Captures an 8x8 quantized block, scans it in JPEG zigzag order and emits
// DC, AC (run, value) pairs, ZRL markers and a closing EOB over valid/ready.
module zigzag_rle #(
    parameter int unsigned COEFF_W = 52,
    parameter int unsigned VAL_W   = 16
) (
    input logic         clk,
    input logic         rst_n,
    zigzag_rle_if.slave bus_io
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StScan = 3'd1;
    localparam logic [2:0] StZrl  = 3'd2;
    localparam logic [2:0] StSym  = 3'd3;
    localparam logic [2:0] StEob  = 3'd4;

    // Zigzag index -> row*8+col of the natural-order block.
    localparam logic [5:0] ZzPos [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [VAL_W-1:0] sat(input logic signed [COEFF_W-1:0] c);
        logic signed [COEFF_W-1:0] hi;
        logic signed [COEFF_W-1:0] lo;
        hi = {{(COEFF_W-VAL_W+1){1'b0}}, {(VAL_W-1){1'b1}}};
        lo = {{(COEFF_W-VAL_W+1){1'b1}}, {(VAL_W-1){1'b0}}};
        if (c > hi)      sat = {1'b0, {(VAL_W-1){1'b1}}};
        else if (c < lo) sat = {1'b1, {(VAL_W-1){1'b0}}};
        else             sat = c[VAL_W-1:0];
    endfunction

    logic [2:0]                 state_q, state_d;
    logic [5:0]                 idx_q, idx_d;
    logic [5:0]                 zrun_q, zrun_d;
    logic                       out_valid_q, out_valid_d;
    logic [3:0]                 out_run_q, out_run_d;
    logic [VAL_W-1:0]           out_value_q, out_value_d;
    logic                       out_eob_q, out_eob_d;
    logic                       block_sent_q, block_sent_d;
    // Stored already saturated and in zigzag order; zero-ness is unchanged by saturation.
    logic [63:0][VAL_W-1:0]     coef_q, coef_d;
    logic [VAL_W-1:0]           cur;
    logic [5:0]                 zrun_sub;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        zrun_d       = zrun_q;
        out_valid_d  = out_valid_q;
        out_run_d    = out_run_q;
        out_value_d  = out_value_q;
        out_eob_d    = out_eob_q;
        block_sent_d = 1'b0;
        coef_d       = coef_q;
        cur          = coef_q[idx_q];
        zrun_sub     = zrun_q - 6'd16;

        case (state_q)
            StIdle: begin
                if (bus_io.block_done) begin
                    for (int i = 0; i < 64; i++) begin
                        coef_d[i] = sat(bus_io.quantized_coeffs[ZzPos[i][5:3]][ZzPos[i][2:0]]);
                    end
                    idx_d   = 6'd0;
                    zrun_d  = 6'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (idx_q == 6'd0) begin
                    out_valid_d = 1'b1;
                    out_run_d   = 4'd0;
                    out_value_d = cur;
                    out_eob_d   = 1'b0;
                    state_d     = StSym;
                end else if (cur == '0) begin
                    zrun_d = zrun_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        // Trailing zeros are absorbed by EOB.
                        out_valid_d = 1'b1;
                        out_run_d   = 4'd0;
                        out_value_d = '0;
                        out_eob_d   = 1'b1;
                        state_d     = StEob;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else if (zrun_q >= 6'd16) begin
                    out_valid_d = 1'b1;
                    out_run_d   = 4'd15;
                    out_value_d = '0;
                    out_eob_d   = 1'b0;
                    state_d     = StZrl;
                end else begin
                    out_valid_d = 1'b1;
                    out_run_d   = zrun_q[3:0];
                    out_value_d = cur;
                    out_eob_d   = 1'b0;
                    state_d     = StSym;
                end
            end
            StZrl: begin
                if (bus_io.out_ready) begin
                    zrun_d = zrun_sub;
                    if (zrun_sub < 6'd16) begin
                        out_run_d   = zrun_sub[3:0];
                        out_value_d = cur;
                        state_d     = StSym;
                    end
                end
            end
            StSym: begin
                if (bus_io.out_ready) begin
                    zrun_d = 6'd0;
                    if (idx_q == 6'd63) begin
                        out_run_d   = 4'd0;
                        out_value_d = '0;
                        out_eob_d   = 1'b1;
                        state_d     = StEob;
                    end else begin
                        out_valid_d = 1'b0;
                        idx_d       = idx_q + 6'd1;
                        state_d     = StScan;
                    end
                end
            end
            StEob: begin
                if (bus_io.out_ready) begin
                    out_valid_d  = 1'b0;
                    out_run_d    = 4'd0;
                    out_value_d  = '0;
                    out_eob_d    = 1'b0;
                    block_sent_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= 6'd0;
            zrun_q       <= 6'd0;
            out_valid_q  <= 1'b0;
            out_run_q    <= 4'd0;
            out_value_q  <= '0;
            out_eob_q    <= 1'b0;
            block_sent_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            zrun_q       <= zrun_d;
            out_valid_q  <= out_valid_d;
            out_run_q    <= out_run_d;
            out_value_q  <= out_value_d;
            out_eob_q    <= out_eob_d;
            block_sent_q <= block_sent_d;
        end
    end

    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign bus_io.in_ready   = (state_q == StIdle);
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_run    = out_run_q;
    assign bus_io.out_value  = out_value_q;
    assign bus_io.out_eob    = out_eob_q;
    assign bus_io.block_sent = block_sent_q;

endmodule
